rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the two register-file write ports (A, B) among NUM_REQ writeback requesters, e.g. ALU, MULT/DIV and LSU.
- Each requester has a valid/ready handshake feeding a 1-entry holding slot.
- Up to two slots are issued per cycle, in round-robin order.
- Reports per-read-port hazards for reads that target registers with writes still pending.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
ADDR_WIDTH, 5, register address width
DATA_WIDTH, 32, register data width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush_i  input  1  synchronous clear of all pending slots
req_valid_i  input  NUM_REQ  requester i has a write
req_ready_o  output  NUM_REQ  requester i may hand over its write
req_addr_i  input  NUM_REQ*ADDR_WIDTH  destination address, requester i in slice i
req_data_i  input  NUM_REQ*DATA_WIDTH  write data, requester i in slice i
waddr_a_o  output  ADDR_WIDTH  port A write address
wdata_a_o  output  DATA_WIDTH  port A write data
we_a_o  output  1  port A write enable
waddr_b_o  output  ADDR_WIDTH  port B write address
wdata_b_o  output  DATA_WIDTH  port B write data
we_b_o  output  1  port B write enable
raddr_i  input  3*ADDR_WIDTH  read addresses a/b/c
hazard_o  output  3  read k targets a pending write

Behaviour:
- State:
  - per-requester slot {valid, addr, data};
  - round-robin pointer rr_ptr, width clog2(NUM_REQ).
- Reset (async, rst_n=0):
  - all slot.valid=0, rr_ptr=0;
  - we_a_o=we_b_o=0, hazard_o=0;
  - req_ready_o = all ones once flush_i=0;
  - addr/data outputs = 0.
- Handshake:
  - Transfer on any rising edge where req_valid_i[i] & req_ready_o[i].
  - req_ready_o[i] = ~flush_i & (~slot[i].valid | slot i issued this cycle). This gives 1 write/cycle/requester throughput.
  - req_addr_i and req_data_i are sampled only at transfer.
  - Requesters must hold valid, addr and data until transfer.
- x0 rule: a transfer with addr==0 completes the handshake, but the slot is not loaded and nothing is written.
- Issue, combinational from registered state only; outputs never depend combinationally on req_*_i:
  - Scan slots in order rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first valid slot goes to port A; the next valid slot with a different addr goes to port B.
  - we_b_o=1 only if we_a_o=1.
  - A slot whose addr equals the port-A slot's addr is skipped this cycle; a later valid slot may take port B.
- Latency: data transferred at edge E0 is written to the regfile at edge E1. One cycle in the slot; no combinational bypass.
- Issued slots clear at the edge unless reloaded by a simultaneous transfer, in which case reload wins.
- rr_ptr update:
  - after an issue, rr_ptr <= (index of last issued slot + 1) mod NUM_REQ;
  - unchanged when nothing issues.
- Starvation bound: any valid slot issues within NUM_REQ cycles.
- hazard_o[k]=1 iff raddr_k != 0 and some valid slot has addr == raddr_k. Combinational; includes slots issuing this cycle.
- flush_i=1:
  - all ready=0 and we_a_o=we_b_o=0 that cycle;
  - all slots cleared and rr_ptr=0 at the edge;
  - flush has priority over issue and transfer.
- Reset mid-operation: pending writes are discarded; no partial write occurs after rst_n falls.
- Same-address writes from two requesters are serialised in round-robin order; the later one overwrites.

Test Plan:
- Reset then idle: rst_n low 3 cycles, no valids -> we_a_o=we_b_o=0, req_ready_o=3'b111, hazard_o=0.
- Single write: req0 addr=5, data=0xDEADBEEF for 1 cycle -> next cycle we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF, we_b_o=0; hazard_o[0]=1 with raddr_a=5 during that cycle, 0 after.
- Three requesters every cycle, addrs 1/2/3, rr_ptr=0:
  - cycle 1: A=req0, B=req1, rr_ptr becomes 2, req2 held with ready=0;
  - cycle 2: A=req2, B=req0;
  - each requester sustains at least 2 writes per 3 cycles.
- Same address: req0 and req1 both addr=7, data 0x11/0x22 in the same cycle -> cycle 1: we_a_o=1 with 0x11, we_b_o=0; cycle 2: we_a_o=1 with 0x22.
- x0 discard: req1 addr=0 -> handshake completes; no we asserted; hazard_o=0 with raddr=0.
- Flush and async reset mid-flight:
  - two slots pending, flush_i=1 -> no writes that cycle or after; ready returns to all ones next cycle;
  - repeat with rst_n pulled low mid-cycle -> we_a_o drops immediately.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter sharing two regfile write ports among NUM_REQ writeback sources
// Each requester owns a 1-entry slot; up to two slots with distinct addresses retire per cycle.
module rf_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  output logic [ADDR_WIDTH-1:0]           waddr_a_o,
  output logic [DATA_WIDTH-1:0]           wdata_a_o,
  output logic                            we_a_o,
  output logic [ADDR_WIDTH-1:0]           waddr_b_o,
  output logic [DATA_WIDTH-1:0]           wdata_b_o,
  output logic                            we_b_o,
  input  logic [3*ADDR_WIDTH-1:0]         raddr_i,
  output logic [2:0]                      hazard_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0]    slot_valid;
  logic [ADDR_WIDTH-1:0] slot_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] slot_data [NUM_REQ];
  logic [PTR_W-1:0]      rr_ptr;

  logic             a_found, b_found;
  logic [PTR_W-1:0] a_idx, b_idx, scan_idx, last_idx, rr_next;
  logic [PTR_W:0]   scan_sum, next_sum;
  logic [NUM_REQ-1:0] issued;

  // Scan from rr_ptr; port B skips any slot that collides with port A's address.
  always_comb begin
    a_found  = 1'b0;
    b_found  = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(off);
      if (scan_sum >= NUM_REQ_W)
        scan_sum = scan_sum - NUM_REQ_W;
      scan_idx = scan_sum[PTR_W-1:0];
      if (slot_valid[scan_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = scan_idx;
        end else if (!b_found && (slot_addr[scan_idx] != slot_addr[a_idx])) begin
          b_found = 1'b1;
          b_idx   = scan_idx;
        end
      end
    end
  end

  assign we_a_o = a_found & ~flush_i;
  assign we_b_o = b_found & we_a_o;

  assign waddr_a_o = we_a_o ? slot_addr[a_idx] : '0;
  assign wdata_a_o = we_a_o ? slot_data[a_idx] : '0;
  assign waddr_b_o = we_b_o ? slot_addr[b_idx] : '0;
  assign wdata_b_o = we_b_o ? slot_data[b_idx] : '0;

  always_comb begin
    issued = '0;
    if (we_a_o) issued[a_idx] = 1'b1;
    if (we_b_o) issued[b_idx] = 1'b1;
  end

  assign req_ready_o = {NUM_REQ{~flush_i}} & (~slot_valid | issued);

  always_comb begin
    last_idx = we_b_o ? b_idx : a_idx;
    next_sum = {1'b0, last_idx} + (PTR_W+1)'(1);
    if (next_sum >= NUM_REQ_W)
      next_sum = '0;
    rr_next = next_sum[PTR_W-1:0];
  end

  // Pending slots, including ones retiring this cycle, hold back reads of their address.
  always_comb begin
    hazard_o = '0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (slot_valid[i] && (raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
            (slot_addr[i] == raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]))
          hazard_o[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
      end
    end else if (flush_i) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        // A reload in the same cycle as issue wins; writes to x0 are dropped here.
        if (req_valid_i[i] && req_ready_o[i]) begin
          slot_valid[i] <= (req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] != '0);
          slot_addr[i]  <= req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
          slot_data[i]  <= req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (issued[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      if (we_a_o)
        rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush_i = 1'b0;
  logic [NR-1:0]     req_valid_i = '0;
  logic [NR-1:0]     req_ready_o;
  logic [NR*AW-1:0]  req_addr_i = '0;
  logic [NR*DW-1:0]  req_data_i = '0;
  logic [AW-1:0]     waddr_a_o, waddr_b_o;
  logic [DW-1:0]     wdata_a_o, wdata_b_o;
  logic              we_a_o, we_b_o;
  logic [3*AW-1:0]   raddr_i = '0;
  logic [2:0]        hazard_o;

  int n_cmp = 0;
  int n_bad = 0;
  int xfer_cnt [NR];

  rf_write_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
    .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .we_b_o(we_b_o),
    .raddr_i(raddr_i), .hazard_o(hazard_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr_i[i*AW +: AW] = a;
    req_data_i[i*DW +: DW] = d;
  endtask

  initial begin
    // reset then idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_we_a", we_a_o, 0);
    check("rst_we_b", we_b_o, 0);
    check("rst_ready", req_ready_o, 3'b111);
    check("rst_hazard", hazard_o, 0);
    check("rst_waddr_a", waddr_a_o, 0);
    rst_n = 1'b1;
    tick();

    // single write
    set_req(0, 5, 32'hDEADBEEF);
    raddr_i = {5'd0, 5'd0, 5'd5};
    req_valid_i = 3'b001;
    #1;
    check("single_pre_hazard", hazard_o, 0);
    tick();
    req_valid_i = '0;
    #1;
    check("single_we_a", we_a_o, 1);
    check("single_waddr_a", waddr_a_o, 5);
    check("single_wdata_a", wdata_a_o, 32'hDEADBEEF);
    check("single_we_b", we_b_o, 0);
    check("single_hazard", hazard_o, 3'b001);
    tick();
    check("single_after_we_a", we_a_o, 0);
    check("single_after_hazard", hazard_o, 0);
    raddr_i = '0;

    // three requesters streaming, rr_ptr starts at 0 after the single write
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    set_req(0, 1, 32'hA0);
    set_req(1, 2, 32'hB0);
    set_req(2, 3, 32'hC0);
    req_valid_i = 3'b111;
    tick();
    check("rr_c1_waddr_a", waddr_a_o, 1);
    check("rr_c1_wdata_a", wdata_a_o, 32'hA0);
    check("rr_c1_we_b", we_b_o, 1);
    check("rr_c1_waddr_b", waddr_b_o, 2);
    check("rr_c1_ready", req_ready_o, 3'b011);
    tick();
    check("rr_c2_waddr_a", waddr_a_o, 3);
    check("rr_c2_waddr_b", waddr_b_o, 1);
    check("rr_c2_wdata_b", wdata_b_o, 32'hA0);
    check("rr_c2_ready", req_ready_o, 3'b101);
    for (int i = 0; i < NR; i++) xfer_cnt[i] = 0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NR; i++)
        if (req_valid_i[i] && req_ready_o[i]) xfer_cnt[i]++;
      tick();
    end
    for (int i = 0; i < NR; i++)
      check($sformatf("rr_throughput_%0d", i), 64'(xfer_cnt[i] >= 4), 1);
    req_valid_i = '0;
    repeat (3) tick();
    check("rr_drained", we_a_o, 0);

    // same address from two requesters
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    set_req(0, 7, 32'h11);
    set_req(1, 7, 32'h22);
    req_valid_i = 3'b011;
    tick();
    req_valid_i = '0;
    #1;
    check("same_c1_we_a", we_a_o, 1);
    check("same_c1_wdata_a", wdata_a_o, 32'h11);
    check("same_c1_we_b", we_b_o, 0);
    tick();
    check("same_c2_we_a", we_a_o, 1);
    check("same_c2_waddr_a", waddr_a_o, 7);
    check("same_c2_wdata_a", wdata_a_o, 32'h22);
    tick();

    // x0 discard
    set_req(1, 0, 32'h55);
    req_valid_i = 3'b010;
    #1;
    check("x0_ready", req_ready_o[1], 1);
    tick();
    req_valid_i = '0;
    #1;
    check("x0_we_a", we_a_o, 0);
    check("x0_we_b", we_b_o, 0);
    check("x0_hazard", hazard_o, 0);

    // flush with two slots pending
    set_req(0, 9, 32'h99);
    set_req(1, 10, 32'hAA);
    req_valid_i = 3'b011;
    tick();
    req_valid_i = '0;
    raddr_i = {5'd9, 5'd10, 5'd0};
    #1;
    check("flush_pre_hazard", hazard_o, 3'b110);
    flush_i = 1'b1;
    #1;
    check("flush_we_a", we_a_o, 0);
    check("flush_we_b", we_b_o, 0);
    check("flush_ready", req_ready_o, 0);
    tick();
    flush_i = 1'b0;
    #1;
    check("flush_after_we_a", we_a_o, 0);
    check("flush_after_ready", req_ready_o, 3'b111);
    check("flush_after_hazard", hazard_o, 0);
    tick();
    check("flush_later_we_a", we_a_o, 0);

    // async reset mid-cycle
    req_valid_i = 3'b011;
    tick();
    req_valid_i = '0;
    #1;
    check("arst_pre_we_a", we_a_o, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_we_a", we_a_o, 0);
    check("arst_we_b", we_b_o, 0);
    check("arst_hazard", hazard_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_after_we_a", we_a_o, 0);
    check("arst_after_ready", req_ready_o, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
